// File: rtl/chebyshev_pkg.sv
// -----------------------------------------------------------------------------
// chebyshev_pkg
// Shared definitions for the Chebyshev-series evaluators.
//   - state_t           : Clenshaw evaluator FSM states (IDLE, ITER, FINAL, OUT)
//   - clog2             : ceiling log2, usable in parameter expressions
//   - widening_f        : accumulator growth bits for a series of given degree
//   - acc_w_f           : accumulator width (CL + widening + 1 sign guard bit)
//   - round_half_up_const : the "one half" constant added before a right shift
// -----------------------------------------------------------------------------
package chebyshev_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 32'sd0;
    v      = value - 32'sd1;
    while (v > 32'sd0) begin
      result = result + 32'sd1;
      v      = v >>> 1;
    end
    return result;
  endfunction

  // Growth of |b_k| over the recurrence is bounded by roughly 2*(N+1) times
  // the largest coefficient, hence clog2(N+1)+1 extra integer bits.
  function automatic int widening_f(input int degree);
    return clog2(degree + 32'sd1) + 32'sd1;
  endfunction

  function automatic int acc_w_f(input int cl, input int degree);
    return cl + widening_f(degree) + 32'sd1;
  endfunction

  // Half an LSB of a value with frac_bits fractional bits to be discarded.
  function automatic longint unsigned round_half_up_const(input int frac_bits);
    return 64'd1 << (frac_bits - 32'sd1);
  endfunction

endpackage

// File: rtl/clenshaw_step.sv
// -----------------------------------------------------------------------------
// clenshaw_step
// Combinational Clenshaw datapath shared by the ITER and FINAL states.
//   t      = round_half_up(x * b1 / 2^(WL-1))
//   result = 2t - b2 + c   (final_mode = 0, recurrence step)
//   result =  t - b2 + c   (final_mode = 1, closing step)
// Sums are formed at ACC_W+2 bits and wrapped to ACC_W.
// Ports:
//   final_mode : selects the closing-step form
//   x          : signed Q1.(WL-1) argument
//   b1, b2     : signed ACC_W recurrence state (CL-1 fractional bits)
//   c          : signed Q1.(CL-1) coefficient, sign-extended internally
//   result     : signed ACC_W step result
// -----------------------------------------------------------------------------
module clenshaw_step
  import chebyshev_pkg::*;
#(
  parameter int WL    = 16,
  parameter int CL    = 16,
  parameter int ACC_W = 21
) (
  input  logic             final_mode,
  input  logic [WL-1:0]    x,
  input  logic [ACC_W-1:0] b1,
  input  logic [ACC_W-1:0] b2,
  input  logic [CL-1:0]    c,
  output logic [ACC_W-1:0] result
);

  localparam int PW = WL + ACC_W;
  localparam int SW = ACC_W + 2;
  localparam logic [PW-1:0] RND_C = PW'(round_half_up_const(WL - 1));

  logic        [PW-1:0] x_ext_s;
  logic        [PW-1:0] b1_ext_s;
  logic signed [PW-1:0] prod_s;
  logic        [SW-1:0] t_s;
  logic        [SW-1:0] lead_s;
  logic        [SW-1:0] b2_ext_s;
  logic        [SW-1:0] c_ext_s;

  // Multiply, round half up, then form the recurrence sum in the wide domain
  always_comb begin
    x_ext_s  = {{ACC_W{x[WL-1]}}, x};
    b1_ext_s = {{WL{b1[ACC_W-1]}}, b1};
    // Operands are sign-extended to the product width, so the low PW bits of
    // the unsigned product are the exact two's-complement product.
    prod_s   = x_ext_s * b1_ext_s + RND_C;
    // t needs ACC_W+1 bits (x=-1, b1=min gives +2^(ACC_W-1)); SW holds 2t.
    t_s      = SW'(prod_s >>> (WL - 1));
    b2_ext_s = {{(SW-ACC_W){b2[ACC_W-1]}}, b2};
    c_ext_s  = {{(SW-CL){c[CL-1]}}, c};
    if (final_mode) begin
      lead_s = t_s;
    end else begin
      lead_s = {t_s[SW-2:0], 1'b0};
    end
    result = ACC_W'(lead_s - b2_ext_s + c_ext_s);
  end

endmodule

// File: rtl/chebyshev_clenshaw.sv
// -----------------------------------------------------------------------------
// chebyshev_clenshaw
// Evaluates y = sum_{k=0..DEGREE} c_k * T_k(x) with the Clenshaw recurrence,
// one iteration per clock. Coefficients are loadable at run time while idle.
// Accept edge is edge 0; out_valid rises at edge DEGREE+1 and is held until
// out_ready is seen.
// Optional build macro: CHEBYSHEV_SATURATE_EN clamps the final result to the
// CL-bit signed coefficient range (sign-extended to ACC_W).
// Ports:
//   clock, resetn          : clock, synchronous active-low reset
//   coeff_we/addr/data     : coefficient write port (honoured only in IDLE,
//                            addr <= DEGREE)
//   in_valid/in_ready      : argument handshake, data_in = x (Q1.(WL-1))
//   out_valid/out_ready    : result handshake, data_out = y (ACC_W bits,
//                            CL-1 fractional bits)
//   busy                   : evaluation in progress (state != IDLE)
// -----------------------------------------------------------------------------
module chebyshev_clenshaw
  import chebyshev_pkg::*;
#(
  parameter  int WL       = 16,
  parameter  int CL       = 16,
  parameter  int DEGREE   = 4,
  localparam int ADDR_W   = clog2(DEGREE + 1),
  localparam int WIDENING = widening_f(DEGREE),
  localparam int ACC_W    = CL + WIDENING + 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              coeff_we,
  input  logic [ADDR_W-1:0] coeff_addr,
  input  logic [CL-1:0]     coeff_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WL-1:0]     data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  data_out,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(DEGREE);
  localparam logic [ADDR_W-1:0] K_ONE  = ADDR_W'(32'd1);
  localparam logic [ADDR_W-1:0] K_ZERO = {ADDR_W{1'b0}};

  state_t             state_r;
  logic [WL-1:0]      x_r;
  logic [ACC_W-1:0]   b1_r;
  logic [ACC_W-1:0]   b2_r;
  logic [ADDR_W-1:0]  k_r;
  logic [CL-1:0]      coeff_r [0:DEGREE];
  logic               in_ready_r;
  logic               out_valid_r;
  logic [ACC_W-1:0]   data_out_r;
  logic               busy_r;

  logic               coeff_wr_s;
  logic               final_mode_s;
  logic [CL-1:0]      c_sel_s;
  logic [ACC_W-1:0]   step_s;
  logic [ACC_W-1:0]   final_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign data_out  = data_out_r;
  assign busy      = busy_r;

  // Coefficient writes are accepted only while idle and in range
  always_comb begin
    if (coeff_we && (state_r == IDLE) && (coeff_addr <= K_LAST)) begin
      coeff_wr_s = 1'b1;
    end else begin
      coeff_wr_s = 1'b0;
    end
  end

  // Coefficient file; cleared by reset so a reset leaves a zero series
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i <= DEGREE; i++) begin
        coeff_r[i] <= {CL{1'b0}};
      end
    end else if (coeff_wr_s) begin
      coeff_r[coeff_addr] <= coeff_data;
    end
  end

  // Select coefficient and step form: c[k] while iterating, c[0] to close
  always_comb begin
    if (state_r == FINAL) begin
      final_mode_s = 1'b1;
      c_sel_s      = coeff_r[K_ZERO];
    end else begin
      final_mode_s = 1'b0;
      c_sel_s      = coeff_r[k_r];
    end
  end

  clenshaw_step #(
    .WL    (WL),
    .CL    (CL),
    .ACC_W (ACC_W)
  ) u_step (
    .final_mode (final_mode_s),
    .x          (x_r),
    .b1         (b1_r),
    .b2         (b2_r),
    .c          (c_sel_s),
    .result     (step_s)
  );

`ifdef CHEBYSHEV_SATURATE_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-CL+1){1'b0}}, {(CL-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {{(ACC_W-CL+1){1'b1}}, {(CL-1){1'b0}}};

  // Clamp the closing result into the signed CL-bit range
  always_comb begin
    if ($signed(step_s) > $signed(SAT_MAX)) begin
      final_s = SAT_MAX;
    end else if ($signed(step_s) < $signed(SAT_MIN)) begin
      final_s = SAT_MIN;
    end else begin
      final_s = step_s;
    end
  end
`else
  // Closing result passes through at full accumulator width
  always_comb begin
    final_s = step_s;
  end
`endif

  // Evaluator FSM with registered handshake and status outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r     <= IDLE;
      x_r         <= {WL{1'b0}};
      b1_r        <= {ACC_W{1'b0}};
      b2_r        <= {ACC_W{1'b0}};
      k_r         <= K_ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      data_out_r  <= {ACC_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            x_r        <= data_in;
            b1_r       <= {ACC_W{1'b0}};
            b2_r       <= {ACC_W{1'b0}};
            k_r        <= K_LAST;
            state_r    <= ITER;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        ITER: begin
          b1_r <= step_s;
          b2_r <= b1_r;
          k_r  <= k_r - K_ONE;
          // k==1 is the last recurrence step; c[0] is folded in by FINAL
          if (k_r == K_ONE) begin
            state_r <= FINAL;
          end
        end
        FINAL: begin
          data_out_r  <= final_s;
          out_valid_r <= 1'b1;
          state_r     <= OUT;
        end
        OUT: begin
          // Returning to IDLE here; the next accept needs a further edge
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chebyshev_clenshaw.sv
// -----------------------------------------------------------------------------
// tb_chebyshev_clenshaw
// Directed-vector bench for chebyshev_clenshaw (WL=CL=16, DEGREE=4).
// Stimulus pushes the hand-computed result into a queue; a monitor pops and
// compares whenever a result is handed over (out_valid && out_ready).
// -----------------------------------------------------------------------------
module tb_chebyshev_clenshaw;
  import chebyshev_pkg::*;

  localparam int WL     = 16;
  localparam int CL     = 16;
  localparam int DEGREE = 4;
  localparam int ADDR_W = clog2(DEGREE + 1);
  localparam int ACC_W  = acc_w_f(CL, DEGREE);

`ifdef CHEBYSHEV_SATURATE_EN
  localparam int ALL_MAX_EXP = 32767;
`else
  localparam int ALL_MAX_EXP = 163805;
`endif

  logic              clock;
  logic              resetn;
  logic              coeff_we;
  logic [ADDR_W-1:0] coeff_addr;
  logic [CL-1:0]     coeff_data;
  logic              in_valid;
  logic              in_ready;
  logic [WL-1:0]     data_in;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  data_out;
  logic              busy;

  int checks;
  int errors;
  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] mon_exp;

  chebyshev_clenshaw #(
    .WL     (WL),
    .CL     (CL),
    .DEGREE (DEGREE)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .coeff_we   (coeff_we),
    .coeff_addr (coeff_addr),
    .coeff_data (coeff_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .busy       (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a handover happens at the coming edge
  always @(negedge clock) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0d expected no result", $signed(data_out));
      end else begin
        mon_exp = exp_q.pop_front();
        check_val("result", $signed(data_out), $signed(mon_exp));
      end
    end
  end

  task automatic write_coeff(input int addr, input int data);
    coeff_addr = ADDR_W'(addr);
    coeff_data = CL'(data);
    coeff_we   = 1'b1;
    @(posedge clock);
    #1;
    coeff_we   = 1'b0;
  endtask

  task automatic load_all(input int c0, input int c1, input int c2, input int c3, input int c4);
    write_coeff(0, c0);
    write_coeff(1, c1);
    write_coeff(2, c2);
    write_coeff(3, c3);
    write_coeff(4, c4);
  endtask

  // Present x and return #1 after the accepting edge
  task automatic send(input int x);
    bit ok;
    ok       = 1'b0;
    data_in  = WL'(x);
    in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_val("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Wait for out_valid (bounded), return edges counted, then one more edge
  task automatic wait_result(output int edges);
    edges = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clock);
      #1;
      edges++;
      if (out_valid) break;
    end
    if (!out_valid) check_val("result_timeout", 0, 1);
    @(posedge clock);
    #1;
  endtask

  task automatic eval(input int x, input int exp);
    int edges;
    exp_q.push_back(ACC_W'(exp));
    send(x);
    wait_result(edges);
    check_val("latency", edges, DEGREE + 1);
  endtask

  initial begin
    int edges;
    checks     = 0;
    errors     = 0;
    resetn     = 1'b0;
    coeff_we   = 1'b0;
    coeff_addr = '0;
    coeff_data = '0;
    in_valid   = 1'b0;
    data_in    = '0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_val("reset_in_ready", in_ready, 1);
    check_val("reset_out_valid", out_valid, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_data_out", $signed(data_out), 0);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Constant term: T0 = 1, also at x = -1
    load_all(16384, 0, 0, 0, 0);
    eval(12345, 16384);
    eval(-32768, 16384);

    // T1(0.5) = 0.5, T1(-1) = -1
    load_all(0, 16384, 0, 0, 0);
    eval(16384, 8192);
    eval(-32768, -16384);

    // T2(0.5) = -0.5, T2(-1) = 1
    load_all(0, 0, 16384, 0, 0);
    eval(16384, -8192);
    eval(-32768, 16384);

    // Backpressure: result held, new x ignored until released
    load_all(0, 16384, 0, 0, 0);
    out_ready = 1'b0;
    exp_q.push_back(ACC_W'(8192));
    send(16384);
    for (int n = 0; n < 100; n++) begin
      if (out_valid) break;
      @(posedge clock);
      #1;
    end
    exp_q.push_back(ACC_W'(-16384));
    data_in  = WL'(-32768);
    in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clock);
      #1;
      check_val("hold_out_valid", out_valid, 1);
      check_val("hold_data_out", $signed(data_out), 8192);
      check_val("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check_val("release_out_valid", out_valid, 0);
    check_val("release_in_ready", in_ready, 1);
    @(posedge clock);
    #1;
    check_val("next_accept_busy", busy, 1);
    check_val("next_accept_in_ready", in_ready, 0);
    in_valid = 1'b0;
    wait_result(edges);

    // Write while busy is dropped; out-of-range write changes nothing
    load_all(16384, 0, 0, 0, 0);
    exp_q.push_back(ACC_W'(16384));
    send(0);
    write_coeff(0, 1000);
    wait_result(edges);
    eval(16384, 16384);
    write_coeff(7, 1000);
    eval(16384, 16384);

    // Full-scale coefficients and argument
    load_all(32767, 32767, 32767, 32767, 32767);
    eval(32767, ALL_MAX_EXP);

    // Reset during ITER aborts and clears the coefficient file
    send(32767);
    @(posedge clock);
    #1;
    resetn = 1'b0;
    @(posedge clock);
    #1;
    check_val("abort_out_valid", out_valid, 0);
    check_val("abort_in_ready", in_ready, 1);
    check_val("abort_busy", busy, 0);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    eval(32767, 0);

    repeat (3) @(posedge clock);
    #1;
    check_val("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
